// File: rtl/argon_bus_pkg.sv
// Shared types and helpers for the load/store unit's Wishbone initiator.
package argon_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    // A request that cannot be issued as a single aligned bus cycle.
    function automatic logic misaligned(input logic [1:0] addr_lo, input lsu_size_t size);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic bundle. data_in flows master->slave, data_out flows slave->master.
interface wishbone_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  select;
    logic        write_enable;
    logic        cycle;
    logic        strobe;
    logic        ack;

    modport master (
        output address, data_in, select, write_enable, cycle, strobe,
        input  data_out, ack
    );

    modport slave (
        input  address, data_in, select, write_enable, cycle, strobe,
        output data_out, ack
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store select/data replication and load lane extraction/extension.
module lsu_align
    import argon_bus_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  lsu_size_t   st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_select,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_addr_lo,
    input  lsu_size_t   ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side: pick the byte enables and replicate the right-justified data on every lane.
    always_comb begin
        st_select = SEL_NONE;
        st_lanes  = '0;
        case (st_size)
            SZ_BYTE: begin
                st_select = SEL_BYTE0 << st_addr_lo;
                st_lanes  = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_select = st_addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
                st_lanes  = {2{st_wdata[15:0]}};
            end
            SZ_WORD: begin
                st_select = SEL_WORD;
                st_lanes  = st_wdata;
            end
            default: begin
                st_select = SEL_NONE;
                st_lanes  = '0;
            end
        endcase
    end

    // Load side: pull the addressed lane out of the bus word, then sign- or zero-extend.
    always_comb begin
        byte_lane = ld_rdata[7:0];
        case (ld_addr_lo)
            2'd0: byte_lane = ld_rdata[7:0];
            2'd1: byte_lane = ld_rdata[15:8];
            2'd2: byte_lane = ld_rdata[23:16];
            2'd3: byte_lane = ld_rdata[31:24];
            default: byte_lane = ld_rdata[7:0];
        endcase
        half_lane = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data   = '0;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            SZ_WORD: ld_data = ld_rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator for the load/store unit: one request at a time,
// misalignment and bus-timeout reported through resp_error.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// LSU_IDLE | ready for a request; bus idle
// LSU_BUS  | cycle/strobe asserted, waiting for ack or timeout
// LSU_RESP | resp_valid pulse; also forces one idle bus clock before the next cycle
module wb_lsu_master
    import argon_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    wishbone_if.master  wishbone
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t  state;
    logic [TW-1:0] timer;
    logic [1:0]  ld_addr_lo;
    lsu_size_t   ld_size;
    logic        ld_unsigned;
    logic        ld_write;
    logic [3:0]  st_select;
    logic [31:0] st_lanes;
    logic [31:0] ld_data;
    lsu_size_t   req_size_t;

    assign req_size_t = lsu_size_t'(req_size);
    assign req_ready  = (state == LSU_IDLE);

    lsu_align u_align (
        .st_addr_lo  (req_addr[1:0]),
        .st_size     (req_size_t),
        .st_wdata    (req_wdata),
        .st_select   (st_select),
        .st_lanes    (st_lanes),
        .ld_addr_lo  (ld_addr_lo),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_rdata    (wishbone.data_out),
        .ld_data     (ld_data)
    );

    // Request sequencing, bus outputs, timeout down-counter and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= LSU_IDLE;
            timer                 <= '0;
            ld_addr_lo            <= 2'b00;
            ld_size               <= SZ_BYTE;
            ld_unsigned           <= 1'b0;
            ld_write              <= 1'b0;
            wishbone.cycle        <= 1'b0;
            wishbone.strobe       <= 1'b0;
            wishbone.write_enable <= 1'b0;
            wishbone.select       <= 4'b0000;
            wishbone.address      <= '0;
            wishbone.data_in      <= '0;
            resp_valid            <= 1'b0;
            resp_error            <= 1'b0;
            resp_rdata            <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        ld_addr_lo  <= req_addr[1:0];
                        ld_size     <= req_size_t;
                        ld_unsigned <= req_unsigned;
                        ld_write    <= req_write;
                        if (misaligned(req_addr[1:0], req_size_t)) begin
                            state      <= LSU_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state                 <= LSU_BUS;
                            timer                 <= TW'(TIMEOUT_CYCLES - 1);
                            wishbone.cycle        <= 1'b1;
                            wishbone.strobe       <= 1'b1;
                            wishbone.write_enable <= req_write;
                            wishbone.address      <= {req_addr[31:2], 2'b00};
                            wishbone.select       <= st_select;
                            wishbone.data_in      <= req_write ? st_lanes : 32'h0;
                        end
                    end
                end
                LSU_BUS: begin
                    if (wishbone.ack) begin
                        state           <= LSU_RESP;
                        wishbone.cycle  <= 1'b0;
                        wishbone.strobe <= 1'b0;
                        resp_valid      <= 1'b1;
                        resp_error      <= 1'b0;
                        resp_rdata      <= ld_write ? 32'h0 : ld_data;
                    end else if (timer == '0) begin
                        state           <= LSU_RESP;
                        wishbone.cycle  <= 1'b0;
                        wishbone.strobe <= 1'b0;
                        resp_valid      <= 1'b1;
                        resp_error      <= 1'b1;
                        resp_rdata      <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LSU_RESP: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule
